demux1x4_aligner: RTL and testbench

//  Receive-side counterpart of the 4-to-1 byte-lane mux: takes the serialized byte stream
//  (one byte per clk, slot order lane0..lane3) and rebuilds the four parallel lanes.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot_ctr.sv | 29 ++
 rtl/demux1x4_aligner.sv | 128 ++++++++++++
 tb/tb_demux1x4_aligner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the byte-lane demux (receive side of the 4-to-1 lane mux).
package demux_pkg;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  localparam int IDLE_FRAMES_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_slot_ctr.sv
// Two-bit slot counter: tracks which lane the current stream byte belongs to.
module demux_slot_ctr
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       align,
  input  logic       advance,
  output logic [1:0] slot,
  output logic       last_slot
);

  // Clear wins over align; align loads 1 because the aligning byte already filled slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= SLOT0;
    end else if (clear) begin
      slot <= SLOT0;
    end else if (align) begin
      slot <= SLOT1;
    end else if (advance) begin
      slot <= slot + 2'd1;
    end
  end

  assign last_slot = (slot == SLOT3);

endmodule

// File: rtl/demux1x4_aligner.sv
// Rebuilds four parallel byte lanes from a serialized stream, one frame every 4 clks.
module demux1x4_aligner
  import demux_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int IDLE_FRAMES = IDLE_FRAMES_DEFAULT
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       valid_out,
  output logic             frame_strobe,
  output logic             aligned
);

  localparam logic [3:0] IDLE_LIMIT = 4'(IDLE_FRAMES);

  state_t           state;
  logic [1:0]       slot;
  logic             last_slot;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;
  logic             sv0;
  logic             sv1;
  logic             sv2;
  logic [3:0]       empty_cnt;

  logic [WIDTH-1:0] lane_data;
  logic [3:0]       frame_valid;
  logic             frame_edge;
  logic             frame_empty;
  logic             drop_to_idle;
  logic             align_now;
  logic             run_now;

  // An invalid slot never carries stale data: it is forced to zero.
  assign lane_data    = valid_in ? in : '0;
  assign frame_valid  = {valid_in, sv2, sv1, sv0};
  assign run_now      = (state == ST_RUN);
  assign align_now    = (state == ST_IDLE) && valid_in;
  assign frame_edge   = run_now && last_slot;
  assign frame_empty  = frame_edge && (frame_valid == 4'b0000);
  assign drop_to_idle = frame_empty && ((empty_cnt + 4'd1) == IDLE_LIMIT);

  demux_slot_ctr u_slot_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear     (drop_to_idle),
    .align     (align_now),
    .advance   (run_now),
    .slot      (slot),
    .last_slot (last_slot)
  );

  // FSM, staging registers, frame outputs and empty-frame counter advance together each byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      stage0       <= '0;
      stage1       <= '0;
      stage2       <= '0;
      sv0          <= 1'b0;
      sv1          <= 1'b0;
      sv2          <= 1'b0;
      out0         <= '0;
      out1         <= '0;
      out2         <= '0;
      out3         <= '0;
      valid_out    <= 4'b0000;
      frame_strobe <= 1'b0;
      empty_cnt    <= 4'd0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            stage0 <= in;
            sv0    <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          case (slot)
            SLOT0: begin
              stage0 <= lane_data;
              sv0    <= valid_in;
            end
            SLOT1: begin
              stage1 <= lane_data;
              sv1    <= valid_in;
            end
            SLOT2: begin
              stage2 <= lane_data;
              sv2    <= valid_in;
            end
            default: begin
              out0         <= stage0;
              out1         <= stage1;
              out2         <= stage2;
              out3         <= lane_data;
              valid_out    <= frame_valid;
              frame_strobe <= 1'b1;
              if (drop_to_idle) begin
                state     <= ST_IDLE;
                empty_cnt <= 4'd0;
              end else if (frame_empty) begin
                empty_cnt <= empty_cnt + 4'd1;
              end else begin
                empty_cnt <= 4'd0;
              end
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign aligned = (state == ST_RUN);

endmodule

// File: tb/tb_demux1x4_aligner.sv
// Self-checking bench for demux1x4_aligner against a frame-level reference model.
module tb_demux1x4_aligner;

  localparam int WIDTH       = 8;
  localparam int IDLE_FRAMES = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             valid_in;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       valid_out;
  logic             frame_strobe;
  logic             aligned;

  int nVectors;
  int nMiscompares;

  // reference model: position within frame (-1 = not aligned), collected bytes, outputs
  int               mPos;
  logic [WIDTH-1:0] mBytes [4];
  logic             mBv    [4];
  int               mEmpties;
  logic [WIDTH-1:0] eOut   [4];
  logic [3:0]       eValid;
  logic             eStrobe;

  demux1x4_aligner #(.WIDTH(WIDTH), .IDLE_FRAMES(IDLE_FRAMES)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .valid_in     (valid_in),
    .out0         (out0),
    .out1         (out1),
    .out2         (out2),
    .out3         (out3),
    .valid_out    (valid_out),
    .frame_strobe (frame_strobe),
    .aligned      (aligned)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    mPos     = -1;
    mEmpties = 0;
    eValid   = 4'b0000;
    eStrobe  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mBytes[k] = '0;
      mBv[k]    = 1'b0;
      eOut[k]   = '0;
    end
  endtask

  // One stream byte seen by the receiver: slot it into the frame, publish on the 4th.
  task automatic modelStep(input logic [WIDTH-1:0] b, input logic v);
    eStrobe = 1'b0;
    if (mPos < 0) begin
      if (v) begin
        mBytes[0] = b;
        mBv[0]    = 1'b1;
        mPos      = 1;
      end
    end else begin
      mBytes[mPos] = v ? b : '0;
      mBv[mPos]    = v;
      if (mPos == 3) begin
        for (int k = 0; k < 4; k++) eOut[k] = mBytes[k];
        eValid  = {mBv[3], mBv[2], mBv[1], mBv[0]};
        eStrobe = 1'b1;
        mEmpties = (eValid == 4'b0000) ? mEmpties + 1 : 0;
        if (mEmpties == IDLE_FRAMES) begin
          mPos     = -1;
          mEmpties = 0;
        end else begin
          mPos = 0;
        end
      end else begin
        mPos = mPos + 1;
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string step);
    checkOne({step, ".out0"}, out0, eOut[0]);
    checkOne({step, ".out1"}, out1, eOut[1]);
    checkOne({step, ".out2"}, out2, eOut[2]);
    checkOne({step, ".out3"}, out3, eOut[3]);
    checkOne({step, ".valid_out"}, {4'b0000, valid_out}, {4'b0000, eValid});
    checkOne({step, ".frame_strobe"}, {7'd0, frame_strobe}, {7'd0, eStrobe});
    checkOne({step, ".aligned"}, {7'd0, aligned}, {7'd0, (mPos >= 0)});
  endtask

  // Present one byte, let one rising edge take it, then compare just after the edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] b, input logic v, input string step);
    in       = b;
    valid_in = v;
    @(posedge clk);
    #1;
    modelStep(b, v);
    checkOutput(step);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    in           = '0;
    valid_in     = 1'b0;
    reset        = 1'b1;
    modelReset();
    #2;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] reset released");

    // idle line, nothing captured
    for (int i = 0; i < 3; i++) applyStimulus(8'h77, 1'b0, "idle");

    // T2: full frame A0 B1 C2 D3
    applyStimulus(8'hA0, 1'b1, "t2");
    applyStimulus(8'hB1, 1'b1, "t2");
    applyStimulus(8'hC2, 1'b1, "t2");
    applyStimulus(8'hD3, 1'b1, "t2");
    checkOne("t2.direct_out0", out0, 8'hA0);
    checkOne("t2.direct_out3", out3, 8'hD3);
    checkOne("t2.direct_valid", {4'b0000, valid_out}, 8'h0F);

    // T3: alternating validity
    applyStimulus(8'h11, 1'b1, "t3");
    applyStimulus(8'h22, 1'b0, "t3");
    applyStimulus(8'h33, 1'b1, "t3");
    applyStimulus(8'h44, 1'b0, "t3");
    checkOne("t3.direct_out1", out1, 8'h00);
    checkOne("t3.direct_out2", out2, 8'h33);
    checkOne("t3.direct_valid", {4'b0000, valid_out}, 8'h05);

    // T4: four back-to-back random full frames
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 1'b1, "t4");

    // T1: reset mid-RUN while slot 2 is pending
    applyStimulus(8'h5C, 1'b1, "t1");
    applyStimulus(8'h6D, 1'b1, "t1");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("t1.async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    applyStimulus(8'h9E, 1'b0, "t1.idle");
    for (int i = 0; i < 4; i++) applyStimulus(8'h90 + 8'(i), 1'b1, "t1.realign");
    checkOne("t1.lane0", out0, 8'h90);

    // T5: sixteen empty slots drop the aligner to IDLE, data holds afterwards
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 1'b0, "t5");
    checkOne("t5.unaligned", {7'd0, aligned}, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 1'b0, "t5.hold");

    // T6: single valid byte realigns and shows up on lane 0 four edges later
    applyStimulus(8'h5A, 1'b1, "t6");
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b0, "t6");
    checkOne("t6.lane0", out0, 8'h5A);
    checkOne("t6.valid", {4'b0000, valid_out}, 8'h01);

    // random traffic mixing busy stretches and long quiet stretches
    for (int blk = 0; blk < 30; blk++) begin
      int density;
      int len;
      density = (blk % 3 == 2) ? 0 : int'($urandom_range(20, 100));
      len     = int'($urandom_range(5, 40));
      for (int i = 0; i < len; i++) begin
        applyStimulus(8'($urandom), ($urandom_range(0, 99) < density), "rand");
      end
    end

    // idle-exit edge immediately followed by a valid byte
    for (int i = 0; i < 20; i++) begin
      if (mPos < 0) break;
      applyStimulus(8'($urandom), 1'b0, "adj.drain");
    end
    applyStimulus(8'hC7, 1'b1, "adj");
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b1, "adj");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
